led_scan_ctrl: RTL and testbench
================================

# led_scan_ctrl

Run/pause/mode controller for the board's 8-LED scanner. It owns the step prescaler, a start/pause button, a clear switch and the pattern register, and drives the LED bank directly. Speed and one of four scan patterns are chosen from the slide switches. It sits between the board I/O (sw, button) and the LED pins.

## Interface
- N, 8: LED/switch width; must be ≥ 8.
- M, 50000000: base step period in clk cycles at speed 0.
- DB_CYCLES, 1000000: button debounce stability window in cycles; used only when LED_SCAN_DEBOUNCE_EN is defined.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sw  in  N  sw[1:0] mode, sw[4:2] speed, sw[N-1] clear; other bits unused.
- btn  in  1  start/pause button, asynchronous to clk, active-high.
- leds  out  N  registered LED drive.
- tick  out  1  one-cycle pulse in the cycle the pattern steps.
- running  out  1  high while in RUN.

## Operation
- btn passes through a 2-FF synchronizer, then a rising-edge detector, giving `press`.
- FSM states:
  - IDLE: leds=0; pattern=seed(mode); prescaler=0.
  - RUN: the prescaler counts and the pattern steps on each terminal count.
  - PAUSE: leds hold the pattern; the prescaler is frozen, not cleared.
- FSM transitions:
  - IDLE→RUN on press: pattern=seed(sw mode); leds=seed in the next cycle.
  - RUN→PAUSE on press.
  - PAUSE→RUN on press.
  - Any state→IDLE while sw[N-1]=1. Clear has priority over press in the same cycle; press is ignored while clear is high.
- Prescaler: 32-bit counter, period P = max(M >> speed, 1). tick asserts when count = P-1; count then returns to 0.
- Speed is sampled every cycle. If a speed change makes count ≥ P-1, tick fires on the next cycle.
- Seeds: modes 00 and 01 use 1 (bit 0); mode 10 uses bit N-1 only; mode 11 uses all ones.
- Step per tick, by mode:
  - 00 bounce: dir register, reset 1 = left. Left: pat<<=1, and if the new pat[N-1]=1 then dir=0. Right: pat>>=1, and if the new pat[0]=1 then dir=1. Each end is lit for exactly one tick. Sequence for N=8: 01,02,04,…,80,40,…,01,02.
  - 01 rotate left: pat = {pat[N-2:0], pat[N-1]}.
  - 10 rotate right: pat = {pat[0], pat[N-1:1]}.
  - 11 blink: pat = ~pat.
- Mode change: the mode register latches sw[1:0] at each tick. If sw[1:0] differs from the latched mode at a tick, that tick loads seed(new mode) and sets dir=1 instead of stepping. Changes made during PAUSE apply at the first tick after resume.
- leds = pat in RUN and PAUSE; 0 in IDLE.

## Timing
- Reset values: leds=0, tick=0, running=0, state IDLE, dir=1, prescaler=0, pat=1, latched mode=00.
- press→state change: btn high at edge k gives the new state visible at edge k+3 (two sync stages plus the edge register). running and leds update in the same cycle as the state.
- tick→leds: leds show the stepped value in the cycle after tick is high. Ticks are exactly P cycles apart in RUN.
- Clear: sw[N-1] sampled high at edge k gives leds=0 and running=0 after edge k+1. The clear switch is not synchronized; it is static by use.
- rst mid-operation: all registers go to reset values immediately. The first press after release behaves as from IDLE.

## Configuration
- LED_SCAN_DEBOUNCE_EN defined: after the synchronizer, a DB_CYCLES counter accepts a level change only after it has been stable for DB_CYCLES consecutive cycles. Press latency becomes 3+DB_CYCLES cycles. Glitches shorter than DB_CYCLES produce no press.
- LED_SCAN_DEBOUNCE_EN undefined: no filter; any synchronized rising edge is a press.

## Test plan
Benches use M=16, N=8, and no debounce unless stated.
- Reset, then press with sw=0 (bounce, speed 0): running=1 three cycles after btn; leds=01. Then leds step 02,04,…,80,40,…,01,02, with tick every 16 cycles.
- Speed: sw[4:2]=3 gives P=2, so a tick every 2 cycles. sw[4:2]=5 (M>>5=0) gives a tick every cycle.
- Pause and resume: press at count 9 → PAUSE; leds hold for 100 cycles with no tick. Press again → the next tick arrives 6 cycles after the resume edge.
- Mode switch in RUN: set sw[1:0]=10 mid-bounce. The next tick loads 80; following ticks give 40, 20, …, 01, 80. Mode 11 alternates FF/00 on each tick.
- Clear and press in the same cycle: state→IDLE, leds=00, running=0. A later press restarts from the seed. Asserting rst mid-RUN gives leds=00 with no clk edge.
- LED_SCAN_DEBOUNCE_EN with DB_CYCLES=8: a 5-cycle btn pulse gives no press. A 20-cycle btn pulse gives running=1 at 11 cycles.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - run/pause/mode controller for the LED scanner
// Optional button debounce filter is enabled by defining LED_SCAN_DEBOUNCE_EN.
module led_scan_ctrl #(
  parameter int N         = 8,
  parameter int M         = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn,
  output logic [N-1:0] leds,
  output logic         tick,
  output logic         running
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [31:0] M_W = 32'(M);

  state_t      state, next_state;
  logic        btn_s1, btn_s2, btn_lvl, btn_lvl_d, press;
  logic        clr_q;
  logic [2:0]  speed_q;
  logic [31:0] period, last, count;
  logic [N-1:0] pat, pat_step;
  logic        dir, dir_step;
  logic [1:0]  mode_q;
  logic        run_stay;
  logic        unused_sw;

  assign unused_sw = ^sw[N-2:5];

  function automatic logic [N-1:0] seed_of(input logic [1:0] m);
    seed_of = '0;
    case (m)
      2'b10:   seed_of[N-1] = 1'b1;
      2'b11:   seed_of = '1;
      default: seed_of[0] = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

`ifdef LED_SCAN_DEBOUNCE_EN
  localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);
  logic [31:0] db_cnt;

  // Level only follows the synchronized button after DB_CYCLES steady samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      btn_lvl <= 1'b0;
    end else if (btn_s2 == btn_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt  <= '0;
      btn_lvl <= btn_s2;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end
`else
  logic [31:0] unused_db;
  assign unused_db = DB_CYCLES;
  assign btn_lvl   = btn_s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_lvl_d <= 1'b0;
      press     <= 1'b0;
      clr_q     <= 1'b0;
      speed_q   <= '0;
    end else begin
      btn_lvl_d <= btn_lvl;
      press     <= btn_lvl & ~btn_lvl_d;
      clr_q     <= sw[N-1];
      speed_q   <= sw[4:2];
    end
  end

  always_comb begin
    period = M_W >> speed_q;
    if (period == '0) period = 32'd1;
    last = period - 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr_q) begin
      next_state = S_IDLE;
    end else if (press) begin
      case (state)
        S_IDLE:  next_state = S_RUN;
        S_RUN:   next_state = S_PAUSE;
        S_PAUSE: next_state = S_RUN;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // The prescaler only advances (and the pattern only steps) when RUN persists.
  always_comb begin
    run_stay = (state == S_RUN) && (next_state == S_RUN);
    running  = (state == S_RUN);
    tick     = run_stay && (count >= last);
  end

  always_comb begin
    pat_step = pat;
    dir_step = dir;
    if (sw[1:0] != mode_q) begin
      pat_step = seed_of(sw[1:0]);
      dir_step = 1'b1;
    end else begin
      case (mode_q)
        2'b00: begin
          if (dir) begin
            pat_step = pat << 1;
            if (pat_step[N-1]) dir_step = 1'b0;
          end else begin
            pat_step = pat >> 1;
            if (pat_step[0]) dir_step = 1'b1;
          end
        end
        2'b01:   pat_step = {pat[N-2:0], pat[N-1]};
        2'b10:   pat_step = {pat[0], pat[N-1:1]};
        default: pat_step = ~pat;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      pat    <= N'(1);
      dir    <= 1'b1;
      mode_q <= 2'b00;
      leds   <= '0;
    end else if (next_state == S_IDLE) begin
      count <= '0;
      pat   <= seed_of(sw[1:0]);
      dir   <= 1'b1;
      leds  <= '0;
    end else if (state == S_IDLE) begin
      // Start: latch the mode so the first tick steps rather than reseeds.
      count  <= '0;
      pat    <= seed_of(sw[1:0]);
      dir    <= 1'b1;
      mode_q <= sw[1:0];
      leds   <= seed_of(sw[1:0]);
    end else if (run_stay) begin
      if (tick) begin
        count  <= '0;
        pat    <= pat_step;
        dir    <= dir_step;
        mode_q <= sw[1:0];
        leds   <= pat_step;
      end else begin
        count <= count + 32'd1;
        leds  <= pat;
      end
    end else begin
      leds <= pat;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - scoreboard bench for led_scan_ctrl (N=8, M=16)
module tb_led_scan_ctrl;
  localparam int N  = 8;
  localparam int M  = 16;
  localparam int DB = 8;
`ifdef LED_SCAN_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         btn;
  logic [N-1:0] sw;
  logic [N-1:0] leds;
  logic         tick;
  logic         running;

  int n_checks = 0;
  int n_errors = 0;
  int bidx;
  logic [N-1:0] exp_q[$];
  logic [7:0] bounce_seq [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  always #5 clk = ~clk;

  led_scan_ctrl #(.N(N), .M(M), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .leds(leds), .tick(tick), .running(running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push_bounce();
    bidx++;
    exp_q.push_back(bounce_seq[bidx % 14]);
  endtask

  task automatic next_tick(input string tag, input int exp_gap);
    int w;
    logic [N-1:0] e;
    w = 0;
    while (tick !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_tick"}, tick, 1);
    if (exp_gap >= 0) check({tag, "_gap"}, w, exp_gap);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_leds"}, leds, e);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [N-1:0] hold;
    rst = 1'b1; btn = 1'b0; sw = '0; bidx = 0;
    repeat (3) @(negedge clk);
    check("rst_leds", leds, 0);
    check("rst_running", running, 0);
    check("rst_tick", tick, 0);
    rst = 1'b0;
    @(negedge clk);
`ifdef LED_SCAN_DEBOUNCE_EN
    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    check("db_glitch", running, 0);
    btn = 1'b1;
    repeat (LAT) @(negedge clk);
    check("db_early", running, 0);
    @(negedge clk);
    check("db_lat", running, 1);
    check("db_seed", leds, 8'h01);
    repeat (8) @(negedge clk);
    btn = 1'b0;
    push_bounce();
    next_tick("db_t1", 7);
    push_bounce();
    next_tick("db_t2", 15);
`else
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    check("run_lat_early", running, 0);
    @(negedge clk);
    check("run_lat", running, 1);
    check("seed_bounce", leds, 8'h01);
    for (int i = 0; i < 15; i++) begin
      push_bounce();
      next_tick("bounce", 15);
    end
    sw = 8'h0C;
    for (int i = 0; i < 6; i++) begin
      push_bounce();
      next_tick("spd3", 1);
    end
    sw = 8'h14;
    for (int i = 0; i < 6; i++) begin
      push_bounce();
      next_tick("spd5", (i == 0) ? 1 : 0);
    end
    sw = 8'h00;
    push_bounce();
    next_tick("spd0", 0);
    repeat (6) @(negedge clk);
    press();
    check("pause_running", running, 0);
    check("pause_leds", leds, 8'h01);
    hold = leds;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick !== 1'b0 || leds !== hold) bad++;
    end
    check("pause_hold", bad, 0);
    press();
    check("resume_running", running, 1);
    push_bounce();
    next_tick("resume", 6);
    sw = 8'h02;
    exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'h20);
    exp_q.push_back(8'h10); exp_q.push_back(8'h08); exp_q.push_back(8'h04);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    for (int i = 0; i < 9; i++) next_tick("rotr", 15);
    sw = 8'h03;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) next_tick("blink", 15);
    sw = 8'h01;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    for (int i = 0; i < 3; i++) next_tick("rotl", 15);
    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sw = 8'h81;
    btn = 1'b0;
    @(negedge clk);
    check("clr_lat", running, 1);
    @(negedge clk);
    check("clr_running", running, 0);
    check("clr_leds", leds, 8'h00);
    sw = 8'h02;
    repeat (10) @(negedge clk);
    check("clr_idle_running", running, 0);
    check("clr_idle_leds", leds, 8'h00);
    press();
    check("restart_running", running, 1);
    check("restart_seed", leds, 8'h80);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_leds", leds, 8'h00);
    check("arst_running", running, 0);
    @(negedge clk);
    rst = 1'b0;
    sw = 8'h00;
    @(negedge clk);
    press();
    check("post_rst_seed", leds, 8'h01);
    bidx = 0;
    push_bounce();
    next_tick("post_rst", 15);
`endif
    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
